// File: rtl/ahbl_irq_ctrl.sv
// AHB-Lite interrupt controller: edge/level latching, per-source mask and priority, claim/complete handshake (IRQC_SYNC_EN adds a 2-flop input synchronizer).
// Latency: IRQ_SRC to IRQ is 2 cycles, or 4 with IRQC_SYNC_EN; register reads are returned in the data phase.
// Backpressure: none, HREADYOUT is tied high (zero wait states).
module ahbl_irq_ctrl #(
    parameter int NSRC   = 8,
    parameter int PRIO_W = 2
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic [31:0]         HADDR,
    input  logic [1:0]          HTRANS,
    input  logic [2:0]          HSIZE,
    input  logic                HWRITE,
    input  logic                HREADY,
    input  logic                HSEL,
    input  logic [31:0]         HWDATA,
    output logic                HREADYOUT,
    output logic [31:0]         HRDATA,
    input  logic [NSRC-1:0]     IRQ_SRC,
    output logic                IRQ,
    output logic [4:0]          IRQ_ID
);

    localparam int PW = NSRC * PRIO_W;

    localparam logic [2:0] REG_PEND   = 3'd0;
    localparam logic [2:0] REG_ENABLE = 3'd1;
    localparam logic [2:0] REG_EDGE   = 3'd2;
    localparam logic [2:0] REG_CLAIM  = 3'd3;
    localparam logic [2:0] REG_PRIO   = 3'd4;
    localparam logic [2:0] REG_STATUS = 3'd5;

    typedef enum logic {ST_IDLE, ST_INSVC} state_t;

    state_t            state;
    logic              dp_vld;
    logic              dp_wr;
    logic [2:0]        dp_sel;
    logic [NSRC-1:0]   pend_r;
    logic [NSRC-1:0]   en_r;
    logic [NSRC-1:0]   edge_r;
    logic [PW-1:0]     prio_r;
    logic [4:0]        cur_id;
    logic              irq_r;
    logic [NSRC-1:0]   s;
    logic [NSRC-1:0]   s_d;

    logic [NSRC-1:0]   cand;
    logic [PRIO_W-1:0] best_prio;
    logic [4:0]        win_id;
    logic [NSRC-1:0]   win_oh;
    logic              wr_pend;
    logic              wr_claim;
    logic              rd_claim;
    logic              claim_take;
    logic [NSRC-1:0]   clr_mask;
    logic [NSRC-1:0]   pend_nxt;
    logic              unused_bits;

    assign unused_bits = ^{HSIZE, HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA};

`ifdef IRQC_SYNC_EN
    logic [NSRC-1:0] sync_q1;
    logic [NSRC-1:0] sync_q2;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= IRQ_SRC;
            sync_q2 <= sync_q1;
        end
    end

    assign s = sync_q2;
`else
    assign s = IRQ_SRC;
`endif

    assign wr_pend    = dp_vld &  dp_wr & (dp_sel == REG_PEND);
    assign wr_claim   = dp_vld &  dp_wr & (dp_sel == REG_CLAIM);
    assign rd_claim   = dp_vld & ~dp_wr & (dp_sel == REG_CLAIM);
    assign claim_take = rd_claim & (state == ST_IDLE) & (win_id != 5'd0);

    assign cand = pend_r & en_r;

    // Strict '>' keeps the lowest index on ties and rejects priority 0.
    always_comb begin
        best_prio = '0;
        win_id    = '0;
        win_oh    = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (cand[i] && (prio_r[i*PRIO_W +: PRIO_W] > best_prio)) begin
                best_prio = prio_r[i*PRIO_W +: PRIO_W];
                win_id    = 5'(i + 1);
                win_oh    = '0;
                win_oh[i] = 1'b1;
            end
        end
    end

    // Edge bits: new rising edge beats any clear in the same cycle; level bits just mirror s.
    assign clr_mask = (wr_pend ? HWDATA[NSRC-1:0] : '0) | (claim_take ? win_oh : '0);
    assign pend_nxt = (edge_r & ((pend_r & ~clr_mask) | (s & ~s_d))) | (~edge_r & s);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_vld <= 1'b0;
            dp_wr  <= 1'b0;
            dp_sel <= '0;
            pend_r <= '0;
            en_r   <= '0;
            edge_r <= '0;
            prio_r <= '0;
            s_d    <= '0;
            state  <= ST_IDLE;
            cur_id <= '0;
            irq_r  <= 1'b0;
        end else begin
            dp_vld <= HSEL & HTRANS[1] & HREADY;
            dp_wr  <= HWRITE;
            dp_sel <= HADDR[4:2];
            pend_r <= pend_nxt;
            s_d    <= s;

            if (dp_vld && dp_wr && dp_sel == REG_ENABLE) en_r   <= HWDATA[NSRC-1:0];
            if (dp_vld && dp_wr && dp_sel == REG_EDGE)   edge_r <= HWDATA[NSRC-1:0];
            if (dp_vld && dp_wr && dp_sel == REG_PRIO)   prio_r <= HWDATA[PW-1:0];

            case (state)
                ST_IDLE: begin
                    if (claim_take) begin
                        state  <= ST_INSVC;
                        cur_id <= win_id;
                        irq_r  <= 1'b0;
                    end else begin
                        irq_r  <= (win_id != 5'd0);
                    end
                end
                ST_INSVC: begin
                    irq_r <= 1'b0;
                    if (wr_claim && (HWDATA[4:0] == cur_id)) begin
                        state  <= ST_IDLE;
                        cur_id <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        HRDATA = '0;
        if (dp_vld && !dp_wr) begin
            case (dp_sel)
                REG_PEND:   HRDATA[NSRC-1:0] = pend_r;
                REG_ENABLE: HRDATA[NSRC-1:0] = en_r;
                REG_EDGE:   HRDATA[NSRC-1:0] = edge_r;
                REG_CLAIM:  if (state == ST_IDLE) HRDATA[4:0] = win_id;
                REG_PRIO:   HRDATA[PW-1:0]   = prio_r;
                REG_STATUS: begin
                    HRDATA[0]   = (state == ST_INSVC);
                    HRDATA[8:4] = cur_id;
                end
                default: HRDATA = '0;
            endcase
        end
    end

    assign HREADYOUT = 1'b1;
    assign IRQ       = irq_r;
    assign IRQ_ID    = (state == ST_IDLE) ? win_id : cur_id;

endmodule

// File: tb/tb_ahbl_irq_ctrl.sv
// Directed and randomized check of ahbl_irq_ctrl against a priority-scan reference model.
module tb_ahbl_irq_ctrl;

    localparam int NSRC = 8;
`ifdef IRQC_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic        HREADY;
    logic        HSEL;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic [NSRC-1:0] IRQ_SRC;
    logic        IRQ;
    logic [4:0]  IRQ_ID;

    int total = 0;
    int bad   = 0;

    ahbl_irq_ctrl #(.NSRC(NSRC), .PRIO_W(2)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE),
        .HWRITE(HWRITE), .HREADY(HREADY), .HSEL(HSEL), .HWDATA(HWDATA),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .IRQ_SRC(IRQ_SRC), .IRQ(IRQ), .IRQ_ID(IRQ_ID)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
        tick();
    endtask

    task automatic bus_rd(input logic [31:0] addr, output logic [31:0] data);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00;
        data = HRDATA;
        tick();
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        bus_rd(addr, d);
        chk(tag, d, exp);
    endtask

    // Scan priority levels from highest down; first enabled pending source at that level wins.
    function automatic int model_winner(input int pend, input int en, input int pr);
        for (int p = 3; p >= 1; p--)
            for (int i = 0; i < NSRC; i++)
                if (pend[i] && en[i] && (((pr >> (2 * i)) & 3) == p))
                    return i + 1;
        return 0;
    endfunction

    initial begin
        logic [31:0] d;
        int en, pr, mask, pend, exp_id;

        HRESET = 1'b1; HADDR = '0; HTRANS = '0; HSIZE = 3'b010; HWRITE = 1'b0;
        HREADY = 1'b1; HSEL = 1'b0; HWDATA = '0; IRQ_SRC = '0;
        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;
        tick();

        // Reset state
        chk("rst_irq", IRQ, 0);
        chk("rst_hreadyout", HREADYOUT, 1);
        chk("rst_irq_id", IRQ_ID, 0);
        chk("rst_hrdata", HRDATA, 0);
        for (int a = 0; a < 8; a++) rd_chk("rst_reg", 32'(a * 4), 0);

        // Single edge source: latency, claim, complete
        bus_wr(32'h04, 1); bus_wr(32'h08, 1); bus_wr(32'h10, 1);
        IRQ_SRC = 8'h01;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            if (k == 1) IRQ_SRC = '0;
            chk("edge_latency", IRQ, (k == LAT) ? 1 : 0);
        end
        rd_chk("edge_pending", 32'h00, 32'h01);
        rd_chk("edge_claim", 32'h0C, 1);
        chk("edge_irq_after_claim", IRQ, 0);
        rd_chk("edge_status_insvc", 32'h14, 32'h11);
        rd_chk("edge_pending_cleared", 32'h00, 0);
        bus_wr(32'h0C, 1);
        rd_chk("edge_status_done", 32'h14, 0);
        chk("edge_irq_done", IRQ, 0);

        // Priority ties and strict priority
        bus_wr(32'h04, 32'h0A); bus_wr(32'h08, 32'h0A); bus_wr(32'h10, 32'h44);
        IRQ_SRC = 8'h0A; tick(); IRQ_SRC = '0;
        repeat (LAT) tick();
        rd_chk("tie_claim", 32'h0C, 2);
        bus_wr(32'h0C, 2);
        bus_wr(32'h10, 32'hC4);
        IRQ_SRC = 8'h02; tick(); IRQ_SRC = '0;
        repeat (LAT) tick();
        rd_chk("prio_claim", 32'h0C, 4);
        bus_wr(32'h0C, 4);
        rd_chk("prio_claim_next", 32'h0C, 2);
        bus_wr(32'h0C, 2);
        rd_chk("prio_pending_empty", 32'h00, 0);

        // Level source, bad complete, re-assert, reset mid-service
        bus_wr(32'h08, 0); bus_wr(32'h04, 32'h04); bus_wr(32'h10, 32'h10);
        IRQ_SRC = 8'h04;
        repeat (LAT + 1) tick();
        rd_chk("lvl_claim", 32'h0C, 3);
        rd_chk("lvl_status", 32'h14, 32'h31);
        bus_wr(32'h0C, 2);
        rd_chk("lvl_bad_complete", 32'h14, 32'h31);
        rd_chk("lvl_claim_insvc", 32'h0C, 0);
        chk("lvl_irq_insvc", IRQ, 0);
        bus_wr(32'h0C, 3);
        chk("lvl_irq_complete_edge", IRQ, 0);
        tick();
        chk("lvl_irq_reassert", IRQ, 1);
        bus_wr(32'h00, 32'h04);
        rd_chk("lvl_w1c_held", 32'h00, 32'h04);
        rd_chk("lvl_claim_again", 32'h0C, 3);
        bus_wr(32'h04, 0); bus_wr(32'h10, 0);
        rd_chk("lvl_mask_keeps_svc", 32'h14, 32'h31);
        HRESET = 1'b1;
        #2;
        chk("rst_mid_irq_id", IRQ_ID, 0);
        chk("rst_mid_irq", IRQ, 0);
        @(posedge HCLK);
        #1 HRESET = 1'b0;
        rd_chk("rst_mid_status", 32'h14, 0);
        rd_chk("rst_mid_enable", 32'h04, 0);
        bus_wr(32'h04, 32'h04); bus_wr(32'h10, 32'h10);
        IRQ_SRC = '0;
        repeat (LAT + 1) tick();
        bus_wr(32'h00, 32'h04);
        rd_chk("lvl_dropped", 32'h00, 0);

        // Set wins over a same-cycle W1C
        bus_wr(32'h04, 1); bus_wr(32'h08, 1); bus_wr(32'h10, 1);
`ifdef IRQC_SYNC_EN
        IRQ_SRC = 8'h01; tick(); IRQ_SRC = '0;
`endif
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h00;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h01;
`ifndef IRQC_SYNC_EN
        IRQ_SRC = 8'h01;
`endif
        tick();
        IRQ_SRC = '0;
        rd_chk("set_wins", 32'h00, 32'h01);
        chk("set_wins_irq", IRQ, 1);
        bus_wr(32'h00, 32'h01);
        rd_chk("w1c_clears", 32'h00, 0);

        // Randomized: pulse a random set of edge sources, then drain by claim/complete
        for (int it = 0; it < 24; it++) begin
            en   = int'($urandom_range(0, 255));
            pr   = int'($urandom_range(0, 65535));
            mask = int'($urandom_range(1, 255));
            bus_wr(32'h08, 32'hFF); bus_wr(32'h04, en); bus_wr(32'h10, pr);
            IRQ_SRC = mask[NSRC-1:0]; tick(); IRQ_SRC = '0;
            repeat (LAT) tick();
            rd_chk("rnd_pending", 32'h00, mask);
            chk("rnd_irq", IRQ, (model_winner(mask, en, pr) != 0) ? 1 : 0);
            pend = mask;
            for (int n = 0; n <= NSRC; n++) begin
                exp_id = model_winner(pend, en, pr);
                bus_rd(32'h0C, d);
                chk("rnd_claim", d, exp_id);
                if (exp_id == 0) break;
                pend = pend & ~(1 << (exp_id - 1));
                chk("rnd_irq_id", IRQ_ID, exp_id);
                bus_wr(32'h0C, exp_id);
            end
            bus_wr(32'h00, 32'hFF);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
